// File: rtl/mux8_rr_sched_if.sv
// mux8_rr_sched_if: request/select/grant bundle between requesters and the round-robin scheduler
interface mux8_rr_sched_if;
    logic [7:0] req;
    logic [2:0] s;
    logic [7:0] grant;
    logic       valid;
    modport master (output req, input s, input grant, input valid);
    modport slave  (input req, output s, output grant, output valid);
endinterface

// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin scheduler sharing one 8:1 mux, holding each grant for up to HOLD_CYCLES
module mux8_rr_sched #(
    parameter int HOLD_CYCLES = 4
) (
    input logic            clk,
    input logic            rst,
    mux8_rr_sched_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0] st;
    logic [2:0] ptr;
    logic [2:0] k;
    logic [3:0] cnt;
    logic [7:0] r;
    logic       done;

    // First set bit scanning p, p+1, ... with 3-bit wrap; downward loop leaves the nearest hit.
    function automatic logic [2:0] arb(input logic [7:0] rq, input logic [2:0] p);
        logic [2:0] idx;
        arb = p;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (rq[idx]) arb = idx;
        end
    endfunction

    always_comb begin
        r    = (st == IDLE) ? bus.req : bus.req & ~({7'b0, ~bus.req[bus.s]} << bus.s);
        k    = arb(r, (st == IDLE) ? ptr : bus.s + 3'd1);
        done = (st == GRANT) && (cnt == 4'd0 || !bus.req[bus.s]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            bus.s     <= 3'd0;
            bus.grant <= 8'h00;
            bus.valid <= 1'b0;
            ptr       <= 3'd0;
            cnt       <= 4'd0;
        end else if ((st == IDLE) ? |r : done) begin
            if (st == GRANT) ptr <= bus.s + 3'd1;
            if (|r) begin
                st        <= GRANT;
                bus.s     <= k;
                bus.grant <= 8'b1 << k;
                bus.valid <= 1'b1;
                cnt       <= 4'(HOLD_CYCLES - 1);
            end else begin
                st        <= IDLE;
                bus.grant <= 8'h00;
                bus.valid <= 1'b0;
            end
        end else if (st == GRANT) begin
            cnt <= cnt - 4'd1;
        end
    end
endmodule
